// File: rtl/gyro_pkg.sv
// Shared constants for the L3G4200D gyro poller: register map, command bytes,
// FSM state encodings and default timing parameters.
package gyro_pkg;

  localparam int CLK_DIV_DEF     = 8;
  localparam int POLL_CYCLES_DEF = 100000;
  localparam int THRESH_DEF      = 1000;

  localparam logic [7:0] REG_CTRL1   = 8'h20;
  localparam logic [7:0] REG_OUT_X_L = 8'h28;

  // Burst read: bit7 = read, bit6 = auto-increment, low six bits = start address.
  localparam logic [7:0] CMD_CFG_ADDR = REG_CTRL1;
  localparam logic [7:0] CMD_CFG_DATA = 8'h0F;
  localparam logic [7:0] CMD_RD_BURST = {2'b11, REG_OUT_X_L[5:0]};

  localparam logic [2:0] S_INIT     = 3'd0;
  localparam logic [2:0] S_CFG_WR   = 3'd1;
  localparam logic [2:0] S_GAP      = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_RD_BURST = 3'd4;
  localparam logic [2:0] S_UPDATE   = 3'd5;

  // Byte to shift out at position idx of the current transaction.
  function automatic logic [7:0] tx_byte_sel(input logic rd, input logic [2:0] idx);
    if (rd) return (idx == 3'd0) ? CMD_RD_BURST : 8'h00;
    return (idx == 3'd0) ? CMD_CFG_ADDR : CMD_CFG_DATA;
  endfunction

endpackage

// File: rtl/gyro_spi.sv
// Mode-3 SPI byte engine: one byte per start, CLK_DIV clk cycles per SCLK half-period.
module gyro_spi #(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx
);

  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);

  logic        active;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sr;
  logic [7:0]  rx_sr;
  logic        load;

  // Handshake: start is honoured when idle or in the done cycle; done is a
  // one-cycle pulse on the last clk of the final high phase, rx valid with it,
  // so a start in that cycle chains bytes with no stretched SCLK high time.
  assign done = active && sclk && (cnt == HALF_LAST) && (bit_cnt == 3'd7);
  assign load = start && (!active || done);
  assign rx   = rx_sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      active  <= 1'b0;
      sclk    <= 1'b1;
      mosi    <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
    end else if (load) begin
      active  <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= tx[7];
      tx_sr   <= {tx[6:0], 1'b0};
      cnt     <= '0;
      bit_cnt <= '0;
    end else if (active) begin
      if (cnt == HALF_LAST) begin
        cnt <= '0;
        if (!sclk) begin
          sclk  <= 1'b1;
          rx_sr <= {rx_sr[6:0], miso};
        end else if (bit_cnt == 3'd7) begin
          active <= 1'b0;
          mosi   <= 1'b0;
        end else begin
          sclk    <= 1'b0;
          mosi    <= tx_sr[7];
          tx_sr   <= {tx_sr[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/top.sv
// L3G4200D poller: configures the gyro once, then burst-reads X/Y/Z forever and
// lights one LED per axis and direction when the reading exceeds THRESH.
module top
  import gyro_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int POLL_CYCLES = POLL_CYCLES_DEF,
  parameter int THRESH      = THRESH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] led,
  output logic       ACL_CSN,
  output logic       ACL_MOSI,
  input  logic       ACL_MISO,
  output logic       ACL_SCLK
);

  localparam logic [31:0] INIT_LAST = 32'(2 * CLK_DIV - 1);
  localparam logic [31:0] GAP_LAST  = 32'(2 * CLK_DIV - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
  localparam logic [31:0] LEAD_LAST = 32'(CLK_DIV);
  localparam int          TH        = THRESH;

  logic [2:0]         state;
  logic [31:0]        cnt;
  logic [2:0]         byte_idx;
  logic               started;
  logic               csn;
  logic [47:0]        data_sr;
  logic signed [15:0] ax_x, ax_y, ax_z;
  logic [5:0]         led_r;

  logic               xfer;
  logic [2:0]         last_idx;
  logic [2:0]         next_idx;
  logic               spi_start;
  logic               spi_done;
  logic [7:0]         tx_byte;
  logic [7:0]         spi_rx;

  always_comb begin
    xfer      = (state == S_CFG_WR) || (state == S_RD_BURST);
    last_idx  = (state == S_CFG_WR) ? 3'd1 : 3'd6;
    spi_start = 1'b0;
    next_idx  = 3'd0;
    if (xfer) begin
      if (!started && cnt == LEAD_LAST) begin
        spi_start = 1'b1;
      end else if (started && spi_done && byte_idx != last_idx) begin
        spi_start = 1'b1;
        next_idx  = byte_idx + 3'd1;
      end
    end
    tx_byte = tx_byte_sel(state == S_RD_BURST, next_idx);
  end

  gyro_spi #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk   (clk),
    .rst   (rst),
    .start (spi_start),
    .tx    (tx_byte),
    .miso  (ACL_MISO),
    .sclk  (ACL_SCLK),
    .mosi  (ACL_MOSI),
    .done  (spi_done),
    .rx    (spi_rx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_INIT;
      cnt      <= '0;
      byte_idx <= '0;
      started  <= 1'b0;
      csn      <= 1'b1;
      data_sr  <= '0;
      ax_x     <= '0;
      ax_y     <= '0;
      ax_z     <= '0;
      led_r    <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (cnt == INIT_LAST) begin
            state    <= S_CFG_WR;
            cnt      <= '0;
            csn      <= 1'b0;
            started  <= 1'b0;
            byte_idx <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_CFG_WR, S_RD_BURST: begin
          if (!started) begin
            if (cnt == LEAD_LAST) started <= 1'b1;
            else                  cnt     <= cnt + 32'd1;
          end else if (spi_done) begin
            // Byte 0 of the burst is the command slot; only data bytes are kept.
            if (state == S_RD_BURST && byte_idx != 3'd0)
              data_sr <= {data_sr[39:0], spi_rx};
            if (byte_idx == last_idx) begin
              csn   <= 1'b1;
              cnt   <= '0;
              state <= (state == S_CFG_WR) ? S_GAP : S_UPDATE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        S_UPDATE: begin
          if (cnt == 32'd0) begin
            ax_x <= {data_sr[39:32], data_sr[47:40]};
            ax_y <= {data_sr[23:16], data_sr[31:24]};
            ax_z <= {data_sr[7:0],   data_sr[15:8]};
            cnt  <= 32'd1;
          end else begin
            led_r <= {int'(ax_z) < -TH, int'(ax_z) > TH,
                      int'(ax_y) < -TH, int'(ax_y) > TH,
                      int'(ax_x) < -TH, int'(ax_x) > TH};
            cnt   <= '0;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_WAIT: begin
          if (cnt == POLL_LAST) begin
            state    <= S_RD_BURST;
            cnt      <= '0;
            csn      <= 1'b0;
            started  <= 1'b0;
            byte_idx <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state <= S_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign ACL_CSN = csn;
  assign led     = led_r;

endmodule

// File: tb/tb_top.sv
// Directed bench for the gyro poller: slave model on the SPI pins, window and
// timing monitor, and step-by-step checks of LEDs, axis values and SPI framing.
module tb_top;

  localparam int CD   = 4;
  localparam int POLL = 200;
  localparam int TH   = 1000;

  logic       clk;
  logic       rst;
  logic [5:0] led;
  logic       csn, mosi, sclk;
  logic       miso = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];

  // stimulus controls written only by the main sequence
  logic        tie1 = 1'b1;
  logic [55:0] frame = '0;
  longint      t_rel = 0;

  // monitor state
  int          win_count = 0;
  int          pulses = 0, last_pulses = 0, sbit = 0;
  logic [63:0] mosi_sr = '0, last_mosi = '0;
  logic        in_win = 0, have_rise = 0, rise_valid = 0, fall_valid = 0, first_fall = 0;
  longint      t_csn_fall = 0, t_csn_rise = 0, t_last_rise = 0, t_fall = 0, first_sclk_t = 0;
  int          cur_gap = 0, gap_min = 1 << 30, bgap_min = 1 << 30;
  int          hi_min = 1 << 30, hi_max = 0, lo_min = 1 << 30, lo_max = 0;
  int          lead_min = 1 << 30, trail_min = 1 << 30, trail_max = 0;

  top #(.CLK_DIV(CD), .POLL_CYCLES(POLL), .THRESH(TH)) dut (
    .clk      (clk),
    .rst      (rst),
    .led      (led),
    .ACL_CSN  (csn),
    .ACL_MOSI (mosi),
    .ACL_MISO (miso),
    .ACL_SCLK (sclk)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // slave model and window/timing monitor
  always @(negedge csn) if (csn === 1'b0) begin
    in_win = 1; pulses = 0; mosi_sr = '0; sbit = 0; first_fall = 1;
    t_csn_fall = $time;
    if (have_rise) begin
      cur_gap = int'(($time - t_csn_rise) / 10);
      if (cur_gap < gap_min) gap_min = cur_gap;
    end else cur_gap = 0;
  end

  always @(posedge csn) if (csn === 1'b1 && in_win) begin
    in_win = 0; have_rise = 1; rise_valid = 0; fall_valid = 0;
    t_csn_rise = $time;
    last_pulses = pulses; last_mosi = mosi_sr;
    if (pulses == 16 || pulses == 56) begin
      if (int'(($time - t_last_rise) / 10) < trail_min) trail_min = int'(($time - t_last_rise) / 10);
      if (int'(($time - t_last_rise) / 10) > trail_max) trail_max = int'(($time - t_last_rise) / 10);
    end
    if (pulses == 56 && cur_gap < bgap_min) bgap_min = cur_gap;
    win_count++;
  end

  always @(negedge sclk) if (in_win && sclk === 1'b0) begin
    if (first_sclk_t == 0) first_sclk_t = $time;
    if (first_fall && int'(($time - t_csn_fall) / 10) < lead_min) lead_min = int'(($time - t_csn_fall) / 10);
    first_fall = 0;
    if (rise_valid) begin
      if (int'(($time - t_last_rise) / 10) < hi_min) hi_min = int'(($time - t_last_rise) / 10);
      if (int'(($time - t_last_rise) / 10) > hi_max) hi_max = int'(($time - t_last_rise) / 10);
    end
    t_fall = $time; fall_valid = 1;
    if (tie1)           miso = 1'b1;
    else if (sbit < 56) miso = frame[55 - sbit];
    else                miso = 1'b1;
    sbit++;
  end

  always @(posedge sclk) if (in_win && sclk === 1'b1) begin
    pulses++;
    mosi_sr = {mosi_sr[62:0], mosi};
    if (fall_valid) begin
      if (int'(($time - t_fall) / 10) < lo_min) lo_min = int'(($time - t_fall) / 10);
      if (int'(($time - t_fall) / 10) > lo_max) lo_max = int'(($time - t_fall) / 10);
    end
    t_last_rise = $time; rise_valid = 1;
  end

  // scoreboard helpers
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_ge(input string tag, input int got, input int lim);
    n_cmp++;
    assert (got >= lim) else begin
      n_bad++;
      $error("FAIL %s got=%0d exp>=%0d", tag, got, lim);
    end
  endtask

  // driver tasks
  task automatic wait_win(input int target, input string tag);
    int i = 0;
    while (win_count < target && i < 20000) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    assert (win_count >= target) else begin
      n_bad++;
      $error("FAIL %s timeout windows=%0d exp=%0d", tag, win_count, target);
    end
  endtask

  task automatic set_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    tie1  = 1'b0;
    frame = {8'h00, x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8]};
  endtask

  task automatic check_axes(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] z);
    repeat (4) @(negedge clk);
    check({tag, "_x"}, {48'h0, dut.ax_x}, {48'h0, x});
    check({tag, "_y"}, {48'h0, dut.ax_y}, {48'h0, y});
    check({tag, "_z"}, {48'h0, dut.ax_z}, {48'h0, z});
    check({tag, "_led"}, {58'h0, led}, {58'h0, exp_q.pop_front()});
  endtask

  // main directed sequence
  initial begin
    int i;
    int wc;
    exp_q.push_back(6'b000000);
    exp_q.push_back(6'b001001);
    exp_q.push_back(6'b100000);
    exp_q.push_back(6'b100001);

    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("reset_outputs", {55'h0, csn, sclk, mosi, led}, {55'h0, 3'b110, 6'b000000});
    end
    rst = 1'b1;
    t_rel = $time;

    // configuration write
    wait_win(1, "cfg_window");
    check("cfg_pulses", 64'(last_pulses), 64'd16);
    check("cfg_mosi", {48'h0, last_mosi[15:0]}, 64'h200F);
    check_ge("first_fall_delay", int'((first_sclk_t - t_rel) / 10), 3 * CD);

    // burst with MISO tied high: every axis reads -1
    wait_win(2, "burst_tie1");
    check("burst_pulses", 64'(last_pulses), 64'd56);
    check("burst_mosi", {8'h0, last_mosi[55:0]}, {8'h0, 8'hE8, 48'h0});
    set_frame(16'h03E9, 16'hFC17, 16'h03E8);
    check_axes("tie1", 16'hFFFF, 16'hFFFF, 16'hFFFF);

    wait_win(3, "burst_p1");
    set_frame(16'hFC18, 16'h03E8, 16'hFC17);
    check_axes("p1", 16'h03E9, 16'hFC17, 16'h03E8);

    wait_win(4, "burst_p2");
    set_frame(16'h7FFF, 16'h0001, 16'h8000);
    check_axes("p2", 16'hFC18, 16'h03E8, 16'hFC17);

    wait_win(5, "burst_p3");
    check_axes("p3", 16'h7FFF, 16'h0001, 16'h8000);

    // abort a burst after 20 SCLK pulses
    i = 0;
    while (!(in_win && pulses >= 20) && i < 20000) begin
      @(negedge clk);
      i++;
    end
    check("abort_in_window", {63'h0, csn}, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_csn_sclk", {62'h0, csn, sclk}, 64'h3);
    check("abort_led", {58'h0, led}, 64'h0);
    check("abort_ax_x", {48'h0, dut.ax_x}, 64'h0);
    check("abort_pulses", 64'(last_pulses), 64'd20);
    repeat (3) @(negedge clk);
    wc = win_count;
    rst = 1'b1;

    wait_win(wc + 1, "cfg_restart");
    check("restart_pulses", 64'(last_pulses), 64'd16);
    check("restart_mosi", {48'h0, last_mosi[15:0]}, 64'h200F);
    repeat (4) @(negedge clk);
    check("restart_led", {58'h0, led}, 64'h0);

    // measured timing over all windows
    check("sclk_high_min", 64'(hi_min), 64'(CD));
    check("sclk_high_max", 64'(hi_max), 64'(CD));
    check("sclk_low_min", 64'(lo_min), 64'(CD));
    check("sclk_low_max", 64'(lo_max), 64'(CD));
    check("csn_trail_min", 64'(trail_min), 64'(CD));
    check("csn_trail_max", 64'(trail_max), 64'(CD));
    check_ge("csn_lead", lead_min, CD);
    check_ge("csn_gap", gap_min, 2 * CD);
    check_ge("burst_interval", bgap_min, POLL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
